// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte buffer and dispatch stage that sits directly in front of the UART
// transmitter. The host pushes bytes at clock rate into a circular FIFO.
// A small FSM hands the bytes to the transmitter one at a time over the
// din/din_vld/rfd handshake. Dropped writes and handshake timeouts are
// reported as sticky flags.
//
// Ports
//   clk          system clock, shared with the transmitter
//   rst          synchronous active-high reset
//   wr_data      byte to enqueue
//   wr_en        enqueue strobe, one byte per cycle
//   full         level == DEPTH (registered)
//   almost_full  level >= AF_LEVEL (registered)
//   empty        level == 0 (registered)
//   level        number of bytes stored, 0..DEPTH (registered)
//   ovf          sticky: a write was dropped because the FIFO was full
//   tmo          sticky: transmitter never dropped rfd after a load strobe
//   flag_clr     clears ovf and tmo; wins over a same-cycle set
//   tx_din       byte to the transmitter, held until the next pop
//   tx_din_vld   one-cycle load strobe to the transmitter
//   tx_rfd       transmitter ready-for-data
//   busy         FSM not idle, or bytes still queued
module uart_tx_fifo #(
  parameter int DI_WIDTH    = 8,
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int AF_LEVEL    = DEPTH - 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ARM_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DI_WIDTH-1:0] wr_data,
  input  logic                wr_en,
  output logic                full,
  output logic                almost_full,
  output logic                empty,
  output logic [AW:0]         level,
  output logic                ovf,
  output logic                tmo,
  input  logic                flag_clr,
  output logic [DI_WIDTH-1:0] tx_din,
  output logic                tx_din_vld,
  input  logic                tx_rfd,
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(ARM_TIMEOUT) + 1;

  localparam logic [AW:0]   DEPTH_L  = DEPTH[AW:0];
  localparam logic [AW:0]   AF_L     = AF_LEVEL[AW:0];
  localparam logic [GW-1:0] GAP_L    = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] ARM_LAST = TW'(ARM_TIMEOUT - 1);

  logic [DI_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [AW:0]         r_level;
  logic                r_full;
  logic                r_empty;
  logic                r_af;
  logic                r_ovf;
  logic                r_tmo;
  logic [DI_WIDTH-1:0] r_txDin;
  logic                r_txVld;
  logic [1:0]          r_state;
  logic [GW-1:0]       r_gapCnt;
  logic [TW-1:0]       r_armCnt;

  logic                w_wrAcc;
  logic                w_pop;
  logic                w_tmoEvt;
  logic [AW:0]         w_levelNext;

  // A write is judged against the registered full flag, so a write that
  // coincides with a pop while full is still dropped. A pop only happens
  // on the IDLE->ARM transition.
  always_comb begin
    w_wrAcc     = wr_en && !r_full;
    w_pop       = (r_state == IDLE) && !r_empty && tx_rfd;
    w_tmoEvt    = (r_state == ARM) && tx_rfd && (r_armCnt == ARM_LAST);
    w_levelNext = r_level + {{AW{1'b0}}, w_wrAcc} - {{AW{1'b0}}, w_pop};
  end

  // Storage array; reset only rewinds the pointers, the contents are
  // simply abandoned.
  always_ff @(posedge clk) begin
    if (!rst && w_wrAcc) begin
      r_mem[r_wp] <= wr_data;
    end
  end

  // Pointers, level/status flags, sticky flags and the dispatch FSM.
  // Status flags are derived from the next level so they stay in step
  // with the level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
      r_txDin  <= '0;
      r_txVld  <= 1'b0;
      r_state  <= IDLE;
      r_gapCnt <= '0;
      r_armCnt <= '0;
    end else begin
      r_txVld <= 1'b0;

      if (w_wrAcc) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp    <= r_rp + AW'(1);
        r_txDin <= r_mem[r_rp];
        r_txVld <= 1'b1;
      end

      r_level <= w_levelNext;
      r_full  <= (w_levelNext == DEPTH_L);
      r_empty <= (w_levelNext == '0);
      r_af    <= (w_levelNext >= AF_L);

      // Clear beats a simultaneous set; that event is lost.
      if (flag_clr) begin
        r_ovf <= 1'b0;
      end else if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end
      if (flag_clr) begin
        r_tmo <= 1'b0;
      end else if (w_tmoEvt) begin
        r_tmo <= 1'b1;
      end

      // A byte that times out in ARM counts as consumed and is not retried.
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state  <= ARM;
            r_armCnt <= '0;
          end
        end
        ARM: begin
          if (!tx_rfd) begin
            r_state <= SEND;
          end else if (w_tmoEvt) begin
            r_state <= IDLE;
          end else begin
            r_armCnt <= r_armCnt + TW'(1);
          end
        end
        SEND: begin
          if (tx_rfd) begin
            r_gapCnt <= GAP_L;
            r_state  <= GAP;
          end
        end
        GAP: begin
          if (r_gapCnt <= GW'(1)) begin
            r_state <= IDLE;
          end else begin
            r_gapCnt <= r_gapCnt - GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign full        = r_full;
  assign almost_full = r_af;
  assign empty       = r_empty;
  assign level       = r_level;
  assign ovf         = r_ovf;
  assign tmo         = r_tmo;
  assign tx_din      = r_txDin;
  assign tx_din_vld  = r_txVld;
  assign busy        = (r_state != IDLE) || !r_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed testbench for uart_tx_fifo. A small transmitter model holds
// tx_rfd low for four cycles after each load strobe and logs every byte
// it receives. Each test task drives its own stimulus and checks
// hand-computed expectations inline.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       almost_full;
  logic       empty;
  logic [4:0] level;
  logic       ovf;
  logic       tmo;
  logic       flag_clr;
  logic [7:0] tx_din;
  logic       tx_din_vld;
  logic       tx_rfd;
  logic       busy;

  logic       modelEn;
  logic       manualRfd;
  logic       modelRfd  = 1'b1;
  int         frameLeft = 0;
  int         capCnt    = 0;
  logic [7:0] capMem [256];

  int checks   = 0;
  int failures = 0;
  int capStart;

  always #5 clk = ~clk;

  assign tx_rfd = modelEn ? modelRfd : manualRfd;

  uart_tx_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .almost_full(almost_full),
    .empty      (empty),
    .level      (level),
    .ovf        (ovf),
    .tmo        (tmo),
    .flag_clr   (flag_clr),
    .tx_din     (tx_din),
    .tx_din_vld (tx_din_vld),
    .tx_rfd     (tx_rfd),
    .busy       (busy)
  );

  // Transmitter model: logs every strobed byte; when enabled, answers a
  // strobe by holding rfd low for four cycles.
  always @(negedge clk) begin
    if (tx_din_vld) begin
      capMem[capCnt[7:0]] = tx_din;
      capCnt = capCnt + 1;
      if (modelEn) frameLeft = 4;
    end
    if (frameLeft > 0) begin
      modelRfd  = 1'b0;
      frameLeft = frameLeft - 1;
    end else begin
      modelRfd = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic waitIdle(input int budget);
    int k;
    k = 0;
    while ((busy || !empty) && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (busy || !empty) begin
      failures++;
      $display("[TB] FAIL idle_timeout busy=%0b empty=%0b after %0d cycles", busy, empty, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flag_clr = 1'b0;
    modelEn = 1'b0; manualRfd = 1'b1;
    step(); step();
    checks++; if (level !== 5'd0)  begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1)  begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b/%b exp=0/0", full, almost_full); end
    checks++; if (ovf !== 1'b0 || tmo !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b/%b exp=0/0", ovf, tmo); end
    checks++; if (tx_din !== 8'h00 || tx_din_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx got=%h/%b exp=00/0", tx_din, tx_din_vld); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    modelEn = 1'b1;
  endtask

  task automatic test_single();
    capStart = capCnt;
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    checks++; if (level !== 5'd1 || empty !== 1'b0) begin failures++; $display("[TB] FAIL single_level got=%0d/%b exp=1/0", level, empty); end
    checks++; if (tx_din_vld !== 1'b0) begin failures++; $display("[TB] FAIL single_early_vld got=%b exp=0", tx_din_vld); end
    step();
    checks++; if (tx_din_vld !== 1'b1 || tx_din !== 8'hA5) begin failures++; $display("[TB] FAIL single_dispatch got=%b/%h exp=1/a5", tx_din_vld, tx_din); end
    checks++; if (level !== 5'd0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL single_after_pop level=%0d busy=%b exp=0/1", level, busy); end
    step();
    checks++; if (tx_din_vld !== 1'b0 || tx_din !== 8'hA5) begin failures++; $display("[TB] FAIL single_strobe_len got=%b/%h exp=0/a5", tx_din_vld, tx_din); end
    repeat (5) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_gap got=%b exp=1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_fall got=%b exp=0", busy); end
    checks++; if (capCnt - capStart !== 1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", capCnt - capStart); end
  endtask

  task automatic test_overflow();
    int k;
    modelEn = 1'b0; manualRfd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_data = 8'hFF;
    checks++; if (full !== 1'b1 || level !== 5'd16) begin failures++; $display("[TB] FAIL ovf_full got=%b/%0d exp=1/16", full, level); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("[TB] FAIL ovf_af got=%b exp=1", almost_full); end
    step();
    wr_en = 1'b0;
    checks++; if (ovf !== 1'b1 || level !== 5'd16) begin failures++; $display("[TB] FAIL ovf_set got=%b/%0d exp=1/16", ovf, level); end
    checks++; if (capCnt - capStart !== 1) begin failures++; $display("[TB] FAIL ovf_no_dispatch got=%0d exp=1", capCnt - capStart); end
    capStart = capCnt;
    modelEn = 1'b1;
    k = 0;
    while (capCnt - capStart < 16 && k < 400) begin
      step();
      k++;
    end
    waitIdle(40);
    checks++; if (capCnt - capStart !== 16) begin failures++; $display("[TB] FAIL ovf_drain_count got=%0d exp=16", capCnt - capStart); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (capMem[(capStart + i) & 255] !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL ovf_order[%0d] got=%h exp=%h", i, capMem[(capStart + i) & 255], 8'(i));
      end
    end
    repeat (10) step();
    checks++; if (capCnt - capStart !== 16) begin failures++; $display("[TB] FAIL ovf_dropped_seen got=%0d exp=16", capCnt - capStart); end
  endtask

  task automatic test_almost_full();
    modelEn = 1'b0; manualRfd = 1'b0;
    capStart = capCnt;
    for (int i = 0; i < 11; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      step();
    end
    checks++; if (almost_full !== 1'b0 || level !== 5'd11) begin failures++; $display("[TB] FAIL af_11 got=%b/%0d exp=0/11", almost_full, level); end
    wr_data = 8'h4B;
    step();
    wr_en = 1'b0;
    checks++; if (almost_full !== 1'b1 || level !== 5'd12) begin failures++; $display("[TB] FAIL af_12 got=%b/%0d exp=1/12", almost_full, level); end
    manualRfd = 1'b1;
    step();
    modelEn = 1'b1;
    checks++; if (almost_full !== 1'b0 || level !== 5'd11) begin failures++; $display("[TB] FAIL af_fall got=%b/%0d exp=0/11", almost_full, level); end
    checks++; if (tx_din_vld !== 1'b1 || tx_din !== 8'h40) begin failures++; $display("[TB] FAIL af_first_pop got=%b/%h exp=1/40", tx_din_vld, tx_din); end
    waitIdle(300);
    checks++; if (capCnt - capStart !== 12) begin failures++; $display("[TB] FAIL af_drain_count got=%0d exp=12", capCnt - capStart); end
  endtask

  task automatic test_back_to_back();
    modelEn = 1'b0; manualRfd = 1'b0;
    capStart = capCnt;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
      step();
    end
    checks++; if (level !== 5'd5) begin failures++; $display("[TB] FAIL b2b_pre_level got=%0d exp=5", level); end
    wr_data = 8'h25; manualRfd = 1'b1;
    step();
    wr_en = 1'b0; modelEn = 1'b1;
    checks++; if (level !== 5'd5) begin failures++; $display("[TB] FAIL b2b_same_cycle_level got=%0d exp=5", level); end
    checks++; if (tx_din_vld !== 1'b1 || tx_din !== 8'h20) begin failures++; $display("[TB] FAIL b2b_pop got=%b/%h exp=1/20", tx_din_vld, tx_din); end
    waitIdle(200);
    checks++; if (capCnt - capStart !== 6) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=6", capCnt - capStart); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (capMem[(capStart + i) & 255] !== 8'h20 + 8'(i)) begin
        failures++;
        $display("[TB] FAIL b2b_wrap[%0d] got=%h exp=%h", i, capMem[(capStart + i) & 255], 8'h20 + 8'(i));
      end
    end
  endtask

  task automatic test_timeout();
    modelEn = 1'b0; manualRfd = 1'b1;
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_data = 8'h66;
    step();
    wr_en = 1'b0;
    checks++; if (tx_din_vld !== 1'b1 || tx_din !== 8'h55) begin failures++; $display("[TB] FAIL tmo_first got=%b/%h exp=1/55", tx_din_vld, tx_din); end
    repeat (63) step();
    checks++; if (tmo !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL tmo_early got=%b busy=%b exp=0/1", tmo, busy); end
    step();
    checks++; if (tmo !== 1'b1) begin failures++; $display("[TB] FAIL tmo_set got=%b exp=1", tmo); end
    step();
    modelEn = 1'b1;
    checks++; if (tx_din_vld !== 1'b1 || tx_din !== 8'h66) begin failures++; $display("[TB] FAIL tmo_next got=%b/%h exp=1/66", tx_din_vld, tx_din); end
    checks++; if (ovf !== 1'b1 || tmo !== 1'b1) begin failures++; $display("[TB] FAIL tmo_sticky got=%b/%b exp=1/1", ovf, tmo); end
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    checks++; if (ovf !== 1'b0 || tmo !== 1'b0) begin failures++; $display("[TB] FAIL tmo_clear got=%b/%b exp=0/0", ovf, tmo); end
    waitIdle(60);
  endtask

  task automatic test_reset_mid();
    modelEn = 1'b1;
    capStart = capCnt;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h70 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    checks++; if (level !== 5'd3 || busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre got=%0d/%b exp=3/1", level, busy); end
    rst = 1'b1;
    step();
    checks++; if (level !== 5'd0 || empty !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_flush got=%0d/%b exp=0/1", level, empty); end
    checks++; if (tx_din_vld !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle got=%b/%b exp=0/0", tx_din_vld, busy); end
    rst = 1'b0;
    repeat (20) step();
    checks++; if (capCnt - capStart !== 1) begin failures++; $display("[TB] FAIL rstmid_no_dispatch got=%0d exp=1", capCnt - capStart); end
    checks++; if (empty !== 1'b1 || level !== 5'd0) begin failures++; $display("[TB] FAIL rstmid_stays_empty got=%b/%0d exp=1/0", empty, level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_almost_full();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
